// File: rtl/sccb_write_arbiter_if.sv
// sccb_write_arbiter_if
//   Bundles the requester-side handshake and the SCCB byte-engine control
//   lines that sccb_write_arbiter sits between.
//
//   master : the arbiter's view. It takes req/req_addr/req_data/i2c_ack and
//            drives gnt/done/nack/busy and the engine control lines.
//   slave  : the opposite view, used by whatever models the requesters and
//            the engine (requester logic, engine wrapper or a testbench).
//
//   Signals:
//     req         [N_REQ]    level request per requester
//     req_addr    [8*N_REQ]  register address, slice i is requester i
//     req_data    [8*N_REQ]  register data, slice i is requester i
//     gnt         [N_REQ]    one-hot grant, held for the whole transaction
//     done        [N_REQ]    1-cycle pulse: write ACKed, STOP issued
//     nack        [N_REQ]    1-cycle pulse: transaction aborted on NACK
//     busy                   arbiter not idle
//     i2c_start              1-cycle start pulse to the engine
//     i2c_stop               1-cycle stop pulse to the engine
//     i2c_wr_data [8]        byte handed to the engine
//     i2c_ack     [2]        [1] ack-bit tick, [0] 1=ACK / 0=NACK
interface sccb_write_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_addr;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   nack;
  logic               busy;
  logic               i2c_start;
  logic               i2c_stop;
  logic [7:0]         i2c_wr_data;
  logic [1:0]         i2c_ack;

  modport master (
    input  req, req_addr, req_data, i2c_ack,
    output gnt, done, nack, busy, i2c_start, i2c_stop, i2c_wr_data
  );

  modport slave (
    output req, req_addr, req_data, i2c_ack,
    input  gnt, done, nack, busy, i2c_start, i2c_stop, i2c_wr_data
  );
endinterface

// File: rtl/sccb_write_arbiter.sv
// sccb_write_arbiter
//   Shares a single SCCB byte engine between N_REQ register-write requesters.
//   A granted requester gets one complete 3-phase write (slave address,
//   register address, data). Requesters are served round-robin, a NACK on any
//   byte aborts the write with an immediate STOP, and every STOP is followed
//   by an enforced idle gap before the engine may be started again.
//
//   Parameters:
//     N_REQ       number of requesters (>= 1)
//     GAP_CYCLES  idle cycles after every STOP (0 behaves like 1)
//     SLAVE_ADDR  SCCB write address sent as the first byte
//
//   Ports:
//     clk_100MHz  the only clock
//     rst_n       asynchronous active-low reset
//     bus         sccb_write_arbiter_if.master (requester handshake and
//                 engine control, see the interface file)
module sccb_write_arbiter #(
  parameter int         N_REQ      = 2,
  parameter int         GAP_CYCLES = 65536,
  parameter logic [7:0] SLAVE_ADDR = 8'h42
) (
  input  logic                 clk_100MHz,
  input  logic                 rst_n,
  sccb_write_arbiter_if.master bus
);

  localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int CNT_W   = $clog2(GAP_EFF + 1);
  localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_EFF - 1);
  // Resetting the round-robin pointer to the top index makes requester 0
  // the first winner.
  localparam logic [ID_W-1:0]  ID_RESET = ID_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_DATA,
    S_FIN,
    S_GAP
  } state_t;

  state_t             state;
  state_t             state_next;

  // last_id is both the round-robin pointer and the id of the requester
  // that owns the current transaction: it is loaded with the winner at grant.
  logic [ID_W-1:0]    last_id;
  logic [7:0]         lat_addr;
  logic [7:0]         lat_data;
  logic [CNT_W-1:0]   gap_cnt;

  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    cand;
  logic [7:0]         win_addr;
  logic [7:0]         win_data;
  logic [N_REQ-1:0]   id_onehot;

  logic               grant;
  logic               abort;
  logic               done_evt;
  logic               active;
  logic               ack_ok;
  logic               ack_bad;

  logic [N_REQ-1:0]   gnt_o;
  logic [N_REQ-1:0]   done_o;
  logic [N_REQ-1:0]   nack_o;
  logic               start_o;
  logic               stop_o;
  logic [7:0]         wr_data_o;

  // Only a tick on ack[1] is an event; ack[0] is meaningless without it.
  assign ack_ok  = (bus.i2c_ack == 2'b11);
  assign ack_bad = (bus.i2c_ack == 2'b10);

  // Round-robin search starting at last_id+1 and wrapping. Walking the
  // candidates from farthest to nearest lets the nearest requesting index
  // overwrite the others, so the first hit in search order wins.
  always_comb begin
    winner = last_id;
    cand   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_id) + k) % N_REQ);
      if (bus.req[cand]) begin
        winner = cand;
      end
    end
  end

  // Pick out the winner's operand slices so they can be latched at grant.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_addr = bus.req_addr[i*8 +: 8];
        win_data = bus.req_data[i*8 +: 8];
      end
    end
  end

  // One-hot form of the owning requester, used for gnt/done/nack.
  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      id_onehot[i] = (last_id == ID_W'(i));
    end
  end

  // State register.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and engine-facing outputs. The byte for the engine is
  // presented combinationally in the same cycle as the ACK of the previous
  // byte, so the engine can load it on the ack tick without a bubble.
  // A NACK in any waiting state issues STOP in that same cycle.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    abort      = 1'b0;
    done_evt   = 1'b0;
    start_o    = 1'b0;
    stop_o     = 1'b0;
    wr_data_o  = '0;

    case (state)
      S_IDLE: begin
        if (|bus.req) begin
          grant      = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        start_o    = 1'b1;
        wr_data_o  = SLAVE_ADDR;
        state_next = S_ADDR;
      end
      S_ADDR: begin
        if (ack_ok) begin
          wr_data_o  = lat_addr;
          state_next = S_DATA;
        end else if (ack_bad) begin
          abort = 1'b1;
        end
      end
      S_DATA: begin
        if (ack_ok) begin
          wr_data_o  = lat_data;
          state_next = S_FIN;
        end else if (ack_bad) begin
          abort = 1'b1;
        end
      end
      S_FIN: begin
        if (ack_ok) begin
          stop_o     = 1'b1;
          done_evt   = 1'b1;
          state_next = S_GAP;
        end else if (ack_bad) begin
          abort = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (abort) begin
      stop_o     = 1'b1;
      state_next = S_GAP;
    end
  end

  // Requester-facing outputs. gnt follows the state so it drops on the edge
  // that enters GAP, and everything falls to 0 as soon as reset asserts.
  always_comb begin
    active = (state == S_START) || (state == S_ADDR) ||
             (state == S_DATA)  || (state == S_FIN);
    gnt_o  = active   ? id_onehot : '0;
    done_o = done_evt ? id_onehot : '0;
    nack_o = abort    ? id_onehot : '0;
  end

  // Grant bookkeeping and the post-STOP gap counter. Operands are captured
  // only at grant so later changes on req_addr/req_data cannot disturb a
  // write in flight. The gap counter stops at GAP_LAST and is cleared on the
  // way out of GAP, so it never wraps.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      last_id  <= ID_RESET;
      lat_addr <= '0;
      lat_data <= '0;
      gap_cnt  <= '0;
    end else begin
      if (grant) begin
        last_id  <= winner;
        lat_addr <= win_addr;
        lat_data <= win_data;
      end
      if (state == S_GAP) begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt <= '0;
        end else begin
          gap_cnt <= gap_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.gnt         = gnt_o;
  assign bus.done        = done_o;
  assign bus.nack        = nack_o;
  assign bus.busy        = (state != S_IDLE);
  assign bus.i2c_start   = start_o;
  assign bus.i2c_stop    = stop_o;
  assign bus.i2c_wr_data = wr_data_o;

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// tb_sccb_write_arbiter
//   Directed bench for sccb_write_arbiter (N_REQ=2, GAP_CYCLES=8). A simple
//   engine model answers each byte after a programmable delay, optionally
//   NACKing one byte. A transaction-level reference model predicts every
//   output on every cycle; literal expectations pin byte order, grant order,
//   STOP-to-start spacing and reset behaviour.
module tb_sccb_write_arbiter;

  localparam int         N       = 2;
  localparam int         GAP     = 8;
  localparam int         GAP_EFF = (GAP < 1) ? 1 : GAP;
  localparam logic [7:0] SA      = 8'h42;

  logic clk_100MHz = 1'b0;
  logic rst_n;

  always #5 clk_100MHz = ~clk_100MHz;

  sccb_write_arbiter_if #(.N_REQ(N)) bus ();

  sccb_write_arbiter #(
    .N_REQ      (N),
    .GAP_CYCLES (GAP),
    .SLAVE_ADDR (SA)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .bus        (bus.master)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  bit armed        = 1'b0;

  // engine model controls
  int eng_delay   = 2;
  int eng_nack_at = -1;
  int eng_wait    = 0;
  int eng_byte    = 0;
  bit eng_noise   = 1'b0;

  // reference model state: owner (-1 none), acks received (-1 = start
  // pending), gap cycles still to run, round-robin pointer
  int         m_owner = -1;
  int         m_acks  = 0;
  int         m_gap   = 0;
  int         m_last  = N - 1;
  logic [7:0] m_addr  = '0;
  logic [7:0] m_data  = '0;

  logic [N-1:0] e_gnt, e_done, e_nack;
  logic         e_busy, e_start, e_stop;
  logic [7:0]   e_wr;

  // observation logs
  int start_cnt = 0, stop_cnt = 0, gnt0_cycles = 0;
  int done_cnt[N];
  int nack_cnt[N];
  int last_start_cyc = 0, last_stop_cyc = 0, last_nack_cyc = -1;
  bit have_stop = 1'b0;
  int byte_log[$];
  int grant_log[$];
  int space_log[$];

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [7:0] a0, input logic [7:0] d0,
                               input logic [7:0] a1, input logic [7:0] d1);
    @(posedge clk_100MHz);
    #1;
    bus.req      = r;
    bus.req_addr = {a1, a0};
    bus.req_data = {d1, d0};
  endtask

  function automatic int probe(input int which);
    case (which)
      0:       return start_cnt;
      1:       return stop_cnt;
      2:       return byte_log.size();
      default: return bus.busy ? 0 : 1;
    endcase
  endfunction

  task automatic waitUntil(input int which, input int target, input int budget, input string name);
    bit reached;
    reached = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (probe(which) >= target) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk_100MHz);
      #1;
    end
    if (!reached) reached = (probe(which) >= target);
    checkOutput(name, 32'(reached), 32'd1);
  endtask

  // Engine model: answers each byte eng_delay cycles after the start pulse
  // or after its previous answer. Idle cycles toggle ack[0] with ack[1]=0.
  initial begin
    bus.i2c_ack = 2'b00;
    forever begin
      @(posedge clk_100MHz);
      #1;
      eng_noise   = ~eng_noise;
      bus.i2c_ack = {1'b0, eng_noise};
      if (!rst_n) begin
        eng_wait = 0;
        eng_byte = 0;
      end else if (bus.i2c_start) begin
        eng_wait = eng_delay;
        eng_byte = 0;
      end else if (eng_wait > 0) begin
        eng_wait--;
        if (eng_wait == 0) begin
          bus.i2c_ack = {1'b1, (eng_byte != eng_nack_at)};
          if (eng_byte != eng_nack_at && eng_byte < 2) begin
            eng_byte++;
            eng_wait = eng_delay;
          end
        end
      end
    end
  end

  // Reference model plus per-cycle comparison and logging.
  always @(negedge clk_100MHz) begin
    if (armed) begin
      e_gnt = '0; e_done = '0; e_nack = '0;
      e_busy = 1'b0; e_start = 1'b0; e_stop = 1'b0; e_wr = '0;
      if (!rst_n) begin
        m_owner = -1; m_acks = 0; m_gap = 0; m_last = N - 1;
        have_stop = 1'b0;
      end else if (m_gap > 0) begin
        e_busy = 1'b1;
        m_gap--;
      end else if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (m_owner < 0 && ((bus.req >> c) & 2'b01) != 0) m_owner = c;
        end
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_addr = 8'(bus.req_addr >> (8 * m_owner));
          m_data = 8'(bus.req_data >> (8 * m_owner));
          m_acks = -1;
        end
      end else begin
        e_busy = 1'b1;
        e_gnt  = N'(32'd1 << m_owner);
        if (m_acks < 0) begin
          e_start = 1'b1;
          e_wr    = SA;
          m_acks  = 0;
        end else if (bus.i2c_ack == 2'b11) begin
          if (m_acks == 0) begin
            e_wr = m_addr; m_acks = 1;
          end else if (m_acks == 1) begin
            e_wr = m_data; m_acks = 2;
          end else begin
            e_stop  = 1'b1;
            e_done  = e_gnt;
            m_owner = -1;
            m_gap   = GAP_EFF;
          end
        end else if (bus.i2c_ack == 2'b10) begin
          e_stop  = 1'b1;
          e_nack  = e_gnt;
          m_owner = -1;
          m_gap   = GAP_EFF;
        end
      end

      checkOutput("gnt",       32'(bus.gnt),         32'(e_gnt));
      checkOutput("done",      32'(bus.done),        32'(e_done));
      checkOutput("nack",      32'(bus.nack),        32'(e_nack));
      checkOutput("busy",      32'(bus.busy),        32'(e_busy));
      checkOutput("i2c_start", 32'(bus.i2c_start),   32'(e_start));
      checkOutput("i2c_stop",  32'(bus.i2c_stop),    32'(e_stop));
      checkOutput("wr_data",   32'(bus.i2c_wr_data), 32'(e_wr));

      if (rst_n) begin
        if (bus.gnt[0]) gnt0_cycles++;
        if (bus.i2c_start) begin
          start_cnt++;
          last_start_cyc = cyc;
          byte_log.push_back(int'(bus.i2c_wr_data));
          grant_log.push_back(bus.gnt[1] ? 1 : 0);
          if (have_stop) space_log.push_back(cyc - last_stop_cyc);
        end
        if (bus.i2c_ack == 2'b11 && !bus.i2c_stop && !bus.i2c_start && bus.busy)
          byte_log.push_back(int'(bus.i2c_wr_data));
        if (bus.i2c_stop) begin
          stop_cnt++;
          last_stop_cyc = cyc;
          have_stop = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
          if (bus.done[i]) done_cnt[i]++;
          if (bus.nack[i]) begin
            nack_cnt[i]++;
            last_nack_cyc = cyc;
          end
        end
      end
    end
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0, p0, d0, d1, n0, n1, rel_cyc;
    for (int i = 0; i < N; i++) begin
      done_cnt[i] = 0;
      nack_cnt[i] = 0;
    end
    rst_n        = 1'b1;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    #2;
    rst_n = 1'b0;
    armed = 1'b1;
    repeat (3) @(posedge clk_100MHz);
    #1;

    $display("[TB] reset state");
    checkOutput("reset_busy",  32'(bus.busy),        32'd0);
    checkOutput("reset_gnt",   32'(bus.gnt),         32'd0);
    checkOutput("reset_start", 32'(bus.i2c_start),   32'd0);
    checkOutput("reset_wr",    32'(bus.i2c_wr_data), 32'd0);
    rst_n = 1'b1;

    // Contention: both requesters held, grants must alternate from 0.
    $display("[TB] contention");
    eng_delay = 2; eng_nack_at = -1;
    grant_log.delete(); space_log.delete();
    s0 = start_cnt;
    applyStimulus(2'b11, 8'h10, 8'h20, 8'h30, 8'h40);
    waitUntil(0, s0 + 4, 300, "contention_starts");
    applyStimulus(2'b00, 8'h10, 8'h20, 8'h30, 8'h40);
    waitUntil(3, 1, 200, "contention_idle");
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("contention_grant%0d", i),
                  (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF, 32'(i % 2));
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("contention_space%0d", i),
                  (i < space_log.size()) ? 32'(space_log[i]) : 32'hFFFF, 32'd10);

    // Single write, engine ACKs every byte after 20 cycles.
    $display("[TB] single write");
    eng_delay = 20; eng_nack_at = -1;
    byte_log.delete();
    s0 = start_cnt; p0 = stop_cnt; d0 = done_cnt[0]; gnt0_cycles = 0;
    applyStimulus(2'b01, 8'h12, 8'h04, 8'h00, 8'h00);
    waitUntil(1, p0 + 1, 300, "single_stop");
    applyStimulus(2'b00, 8'h12, 8'h04, 8'h00, 8'h00);
    waitUntil(3, 1, 100, "single_idle");
    checkOutput("single_nbytes", 32'(byte_log.size()), 32'd3);
    checkOutput("single_byte0", (byte_log.size() > 0) ? 32'(byte_log[0]) : 32'hFFFF, 32'h42);
    checkOutput("single_byte1", (byte_log.size() > 1) ? 32'(byte_log[1]) : 32'hFFFF, 32'h12);
    checkOutput("single_byte2", (byte_log.size() > 2) ? 32'(byte_log[2]) : 32'hFFFF, 32'h04);
    checkOutput("single_starts", 32'(start_cnt - s0), 32'd1);
    checkOutput("single_stops",  32'(stop_cnt - p0),  32'd1);
    checkOutput("single_done0",  32'(done_cnt[0] - d0), 32'd1);
    checkOutput("single_gnt0_cycles", 32'(gnt0_cycles), 32'd61);
    checkOutput("single_busy_after_gap", 32'(bus.busy), 32'd0);

    // NACK on the slave address byte.
    $display("[TB] nack in addr");
    eng_delay = 3; eng_nack_at = 0;
    byte_log.delete();
    p0 = stop_cnt; d0 = done_cnt[0]; n0 = nack_cnt[0];
    applyStimulus(2'b01, 8'h33, 8'h44, 8'h00, 8'h00);
    waitUntil(1, p0 + 1, 100, "nack_addr_stop");
    applyStimulus(2'b00, 8'h33, 8'h44, 8'h00, 8'h00);
    waitUntil(3, 1, 100, "nack_addr_idle");
    checkOutput("nack_addr_nack0", 32'(nack_cnt[0] - n0), 32'd1);
    checkOutput("nack_addr_done0", 32'(done_cnt[0] - d0), 32'd0);
    checkOutput("nack_addr_nbytes", 32'(byte_log.size()), 32'd1);
    checkOutput("nack_addr_same_cycle", 32'(last_nack_cyc), 32'(last_stop_cyc));

    // NACK on the data byte, requester 1 alone.
    $display("[TB] nack in fin");
    eng_delay = 3; eng_nack_at = 2;
    byte_log.delete();
    p0 = stop_cnt; d1 = done_cnt[1]; n1 = nack_cnt[1];
    applyStimulus(2'b10, 8'h00, 8'h00, 8'h55, 8'h66);
    waitUntil(1, p0 + 1, 100, "nack_fin_stop");
    applyStimulus(2'b00, 8'h00, 8'h00, 8'h55, 8'h66);
    waitUntil(3, 1, 100, "nack_fin_idle");
    checkOutput("nack_fin_nack1", 32'(nack_cnt[1] - n1), 32'd1);
    checkOutput("nack_fin_done1", 32'(done_cnt[1] - d1), 32'd0);
    checkOutput("nack_fin_byte2", (byte_log.size() > 2) ? 32'(byte_log[2]) : 32'hFFFF, 32'h66);

    // Operands and req change while the register address is being ACKed.
    $display("[TB] operand change");
    eng_delay = 4; eng_nack_at = -1;
    byte_log.delete();
    p0 = stop_cnt; d0 = done_cnt[0];
    applyStimulus(2'b01, 8'h77, 8'h88, 8'h00, 8'h00);
    waitUntil(2, 2, 100, "opchg_in_data");
    applyStimulus(2'b00, 8'hEE, 8'h99, 8'h00, 8'h00);
    waitUntil(1, p0 + 1, 100, "opchg_stop");
    waitUntil(3, 1, 100, "opchg_idle");
    checkOutput("opchg_byte1", (byte_log.size() > 1) ? 32'(byte_log[1]) : 32'hFFFF, 32'h77);
    checkOutput("opchg_byte2", (byte_log.size() > 2) ? 32'(byte_log[2]) : 32'hFFFF, 32'h88);
    checkOutput("opchg_done0", 32'(done_cnt[0] - d0), 32'd1);

    // Reset during DATA, then requester 1 alone with no gap.
    $display("[TB] reset mid-transaction");
    eng_delay = 5; eng_nack_at = -1;
    byte_log.delete();
    applyStimulus(2'b01, 8'h21, 8'h22, 8'h00, 8'h00);
    waitUntil(2, 2, 100, "rstmid_in_data");
    @(posedge clk_100MHz);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_busy",  32'(bus.busy),        32'd0);
    checkOutput("rstmid_gnt",   32'(bus.gnt),         32'd0);
    checkOutput("rstmid_start", 32'(bus.i2c_start),   32'd0);
    checkOutput("rstmid_stop",  32'(bus.i2c_stop),    32'd0);
    checkOutput("rstmid_wr",    32'(bus.i2c_wr_data), 32'd0);
    checkOutput("rstmid_done",  32'(bus.done),        32'd0);
    checkOutput("rstmid_nack",  32'(bus.nack),        32'd0);
    repeat (2) @(posedge clk_100MHz);
    #1;
    bus.req      = 2'b10;
    bus.req_addr = {8'h31, 8'h21};
    bus.req_data = {8'h32, 8'h22};
    s0 = start_cnt; p0 = stop_cnt; d1 = done_cnt[1];
    rel_cyc = cyc;
    rst_n = 1'b1;
    waitUntil(0, s0 + 1, 50, "rstmid_restart");
    checkOutput("rstmid_start_latency", 32'(last_start_cyc - rel_cyc), 32'd1);
    checkOutput("rstmid_winner",
                (grant_log.size() > 0) ? 32'(grant_log[grant_log.size()-1]) : 32'hFFFF, 32'd1);
    waitUntil(1, p0 + 1, 100, "rstmid_stop");
    applyStimulus(2'b00, 8'h21, 8'h22, 8'h31, 8'h32);
    waitUntil(3, 1, 100, "rstmid_idle");
    checkOutput("rstmid_done1", 32'(done_cnt[1] - d1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sccb_write_arbiter.md
# sccb_write_arbiter

Shares one SCCB byte engine (`i2c_top`, started/stopped by pulses, acknowledged via `ack[1:0]`) between `N_REQ` independent register-write requesters, e.g. the power-up init sequencer and a runtime exposure/gain tuner. Each granted requester gets one complete 3-phase SCCB write: slave address, register address, data. The block handles round-robin arbitration, byte sequencing, NACK abort, and the mandatory inter-transaction idle gap. It sits between the requesters and the engine, inside the camera subsystem.

## Interface
- `N_REQ`, 2: number of requesters (≥1).
- `GAP_CYCLES`, 65536: idle cycles enforced after every STOP (0.66 ms at 100 MHz); a value of 0 is treated as 1.
- `SLAVE_ADDR`, 8'h42: SCCB write address sent in the first phase.
- `clk_100MHz` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in N_REQ: level request per requester.
- `req_addr` in 8·N_REQ: register address; slice i belongs to requester i.
- `req_data` in 8·N_REQ: register data; slice i belongs to requester i.
- `gnt` out N_REQ: one-hot; high from grant until the transaction ends.
- `done` out N_REQ: 1-cycle pulse, write ACKed and STOP issued.
- `nack` out N_REQ: 1-cycle pulse, transaction aborted on NACK.
- `busy` out 1: high whenever the state is not IDLE.
- `i2c_start` out 1: 1-cycle start pulse to the engine.
- `i2c_stop` out 1: 1-cycle stop pulse to the engine.
- `i2c_wr_data` out 8: byte for the engine; meaningful only in the cycles listed below, 0 otherwise.
- `i2c_ack` in 2: `[1]` ticks at the ack bit; `[0]` is 1 for ACK and 0 for NACK.

## Operation
- States: IDLE, START, ADDR, DATA, FIN, GAP.
- **IDLE**: if `|req`, choose the winner round-robin, searching from `last+1` and wrapping modulo N_REQ.
  - Latch the winner's `req_addr` and `req_data` slices, set `gnt[winner]`, set `last = winner`, go to START.
- **START**: one cycle. `i2c_start=1`, `i2c_wr_data=SLAVE_ADDR`. Go to ADDR.
- **ADDR**:
  - On `i2c_ack==2'b11`: `i2c_wr_data = latched addr`, go to DATA.
  - On `2'b10`: abort.
  - Otherwise: wait.
- **DATA**:
  - On `2'b11`: `i2c_wr_data = latched data`, go to FIN.
  - On `2'b10`: abort.
- **FIN**:
  - On `2'b11`: `i2c_stop=1`, `done[id]=1`, go to GAP.
  - On `2'b10`: abort.
- **Abort** (any waiting state): same cycle `i2c_stop=1`, `nack[id]=1`, go to GAP.
- **GAP**:
  - `gnt` clears on entry.
  - Counter runs from 0 up to `max(GAP_CYCLES,1)-1`, then the state returns to IDLE.
  - `req` is ignored while in GAP.
- **Latched operands**: `req_addr`/`req_data` are latched at grant; later changes and `req` deassertion mid-transaction are ignored, and the transaction always completes or aborts.
- **Requester protocol**: drop `req` by the cycle after its `done`/`nack` pulse if no further write is wanted. A request still held when GAP ends is re-arbitrated fairly.
- **Ack inputs**: `i2c_ack[1]==0` means no event, whatever the value of `[0]`.
- The gap counter is `$clog2(GAP_CYCLES+1)` bits wide and never wraps.

## Timing
- **Reset values**:
  - All outputs 0.
  - State IDLE, `last = N_REQ-1` (requester 0 wins first), gap counter 0.
  - No gap is enforced after reset.
- **Reset mid-transaction**: outputs drop to 0 asynchronously. No STOP is issued; the engine shares the same reset.
- **Grant latency**: `req` seen high in IDLE at cycle t gives `gnt` and state START at t+1, with `i2c_start` high during t+1.
- **Byte timing**: `i2c_wr_data` changes combinationally in the same cycle as the qualifying `i2c_ack==2'b11`, and is 0 elsewhere except in START.
- **End of transaction**: `done`/`nack` occur in the same cycle as `i2c_stop`; `gnt` falls at the next edge.
- **Minimum spacing**: one STOP to the next `i2c_start` is `max(GAP_CYCLES,1)+2` cycles.

## Test plan
- **Single write**:
  - Stimulus: `req[0]=1`, addr 8'h12, data 8'h04; engine model ACKs every byte after 20 cycles.
  - Required: bytes 42/12/04 in order, one `i2c_start`, one `i2c_stop`, `done[0]` pulse, `gnt[0]` high for the full transaction, `busy` low after GAP.
- **Contention**:
  - Stimulus: `req=2'b11` held continuously, GAP_CYCLES=8.
  - Required: grants alternate 0,1,0,1; each gap between STOP and the next start is 10 cycles.
- **NACK in ADDR**:
  - Stimulus: engine returns 2'b10 after the first byte.
  - Required: `i2c_stop` and `nack[0]` in the same cycle, no further bytes sent, no `done`.
- **NACK in FIN**:
  - Stimulus: engine NACKs the data byte.
  - Required: `nack` pulse; `done` never asserted.
- **Operand change mid-transaction**:
  - Stimulus: `req_addr` changes and `req` drops during DATA.
  - Required: the originally latched bytes complete; `done` still pulses.
- **Reset mid-transaction**:
  - Stimulus: `rst_n` low during DATA.
  - Required: all outputs 0 immediately; after release, `req[1]`-only is granted to requester 1 with no gap delay.
